// File: rtl/eth_tx_arb_pkg.sv
// Shared types and constants for the Ethernet TX frame arbiter.
package eth_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  // tuser bit that carries the frame-error flag to the MAC
  localparam int unsigned TUSER_ERR_BIT  = 0;
  localparam int unsigned BEAT_CNT_WIDTH = 16;

endpackage

// File: rtl/eth_tx_rr_arb.sv
// Combinational rotating-priority selector: picks the first requester
// strictly after last_grant_i, wrapping modulo S_COUNT.
module eth_tx_rr_arb
  import eth_tx_arb_pkg::*;
#(
  parameter int S_COUNT   = 4,
  parameter int SEL_WIDTH = $clog2(S_COUNT)
) (
  input  logic [S_COUNT-1:0]   req_i,
  input  logic [SEL_WIDTH-1:0] last_grant_i,
  output logic [SEL_WIDTH-1:0] grant_o,
  output logic                 any_req_o
);

  localparam logic [SEL_WIDTH:0] S_COUNT_W = (SEL_WIDTH + 1)'(S_COUNT);

  // Candidate at rotation offset gi+1; one extra bit keeps the sum from overflowing.
  logic [SEL_WIDTH-1:0] cand_idx [S_COUNT];

  generate
    for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_cand
      logic [SEL_WIDTH:0] sum;
      assign sum           = {1'b0, last_grant_i} + (SEL_WIDTH + 1)'(gi + 1);
      assign cand_idx[gi]  = (sum >= S_COUNT_W) ? SEL_WIDTH'(sum - S_COUNT_W)
                                                : sum[SEL_WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    grant_o   = '0;
    any_req_o = |req_i;
    // Walk from the farthest offset back so the nearest requester wins.
    for (int k = S_COUNT - 1; k >= 0; k--) begin
      if (req_i[cand_idx[k]]) begin
        grant_o = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one AXI-Stream TX MAC between
// S_COUNT sources, with runaway-frame truncation and source tagging.
module eth_tx_frame_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int S_COUNT       = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int USER_WIDTH    = 1,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int SEL_WIDTH     = $clog2(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [SEL_WIDTH-1:0]          m_axis_tid,
  input  logic                          enable,
  output logic                          grant_valid,
  output logic [SEL_WIDTH-1:0]          grant_index,
  output logic                          stat_truncated,
  output logic [31:0]                   stat_frames
);

  localparam logic [BEAT_CNT_WIDTH-1:0] BEAT_LIMIT = BEAT_CNT_WIDTH'(MAX_FRAME_LEN - 1);

  arb_state_e                state_q, state_d;
  logic [SEL_WIDTH-1:0]      grant_index_q, grant_index_d;
  logic [SEL_WIDTH-1:0]      last_grant_q, last_grant_d;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [31:0]               frames_q, frames_d;
  logic                      trunc_q, trunc_d;

  logic [DATA_WIDTH-1:0] src_data [S_COUNT];
  logic [USER_WIDTH-1:0] src_user [S_COUNT];

  generate
    for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_unpack
      assign src_data[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign src_user[gi] = s_axis_tuser[gi*USER_WIDTH +: USER_WIDTH];
    end
  endgenerate

  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [USER_WIDTH-1:0] sel_user;
  logic                  cut_beat;
  logic [SEL_WIDTH-1:0]  arb_grant;
  logic                  arb_any;

  assign sel_valid = s_axis_tvalid[grant_index_q];
  assign sel_last  = s_axis_tlast[grant_index_q];
  assign sel_data  = src_data[grant_index_q];
  assign sel_user  = src_user[grant_index_q];
  // The MAX_FRAME_LEN-th beat of a frame that has not ended on its own.
  assign cut_beat  = (beat_cnt_q == BEAT_LIMIT) && !sel_last;

  eth_tx_rr_arb #(
    .S_COUNT   (S_COUNT),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rr_arb (
    .req_i        (s_axis_tvalid),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .any_req_o    (arb_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_index_q <= '0;
      last_grant_q  <= SEL_WIDTH'(S_COUNT - 1);
      beat_cnt_q    <= '0;
      frames_q      <= '0;
      trunc_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_index_q <= grant_index_d;
      last_grant_q  <= last_grant_d;
      beat_cnt_q    <= beat_cnt_d;
      frames_q      <= frames_d;
      trunc_q       <= trunc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_index_d = grant_index_q;
    last_grant_d  = last_grant_q;
    beat_cnt_d    = beat_cnt_q;
    frames_d      = frames_q;
    trunc_d       = 1'b0;
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    m_axis_tid    = '0;

    case (state_q)
      IDLE: begin
        if (enable && arb_any) begin
          grant_index_d = arb_grant;
          state_d       = XFER;
        end
      end

      XFER: begin
        m_axis_tvalid                = sel_valid;
        s_axis_tready[grant_index_q] = m_axis_tready;
        m_axis_tdata                 = sel_data;
        m_axis_tid                   = grant_index_q;
        m_axis_tlast                 = sel_last | cut_beat;
        m_axis_tuser                 = sel_user;
        if (cut_beat) begin
          m_axis_tuser[TUSER_ERR_BIT] = 1'b1;
        end
        if (sel_valid && m_axis_tready) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (sel_last) begin
            frames_d     = frames_q + 32'd1;
            last_grant_d = grant_index_q;
            beat_cnt_d   = '0;
            state_d      = IDLE;
          end else if (cut_beat) begin
            frames_d = frames_q + 32'd1;
            trunc_d  = 1'b1;
            state_d  = DRAIN;
          end
        end
      end

      DRAIN: begin
        // Swallow the remainder of the runaway frame without emitting it.
        s_axis_tready[grant_index_q] = 1'b1;
        if (sel_valid && sel_last) begin
          last_grant_d = grant_index_q;
          beat_cnt_d   = '0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign grant_valid    = (state_q != IDLE);
  assign grant_index    = grant_index_q;
  assign stat_truncated = trunc_q;
  assign stat_frames    = frames_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Randomized self-checking bench for eth_tx_frame_arbiter against a
// frame-level reference model of the arbitration and truncation rules.
module tb_eth_tx_frame_arbiter;

  localparam int S    = 4;
  localparam int DW   = 8;
  localparam int UW   = 1;
  localparam int MAXL = 8;
  localparam int SW   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [S*DW-1:0] s_axis_tdata = '0;
  logic [S-1:0]    s_axis_tvalid = '0;
  logic [S-1:0]    s_axis_tready;
  logic [S-1:0]    s_axis_tlast = '0;
  logic [S*UW-1:0] s_axis_tuser = '0;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b0;
  logic            m_axis_tlast;
  logic [UW-1:0]   m_axis_tuser;
  logic [SW-1:0]   m_axis_tid;
  logic            enable = 1'b0;
  logic            grant_valid;
  logic [SW-1:0]   grant_index;
  logic            stat_truncated;
  logic [31:0]     stat_frames;

  eth_tx_frame_arbiter #(
    .S_COUNT       (S),
    .DATA_WIDTH    (DW),
    .USER_WIDTH    (UW),
    .MAX_FRAME_LEN (MAXL),
    .SEL_WIDTH     (SW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tuser   (s_axis_tuser),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tid     (m_axis_tid),
    .enable         (enable),
    .grant_valid    (grant_valid),
    .grant_index    (grant_index),
    .stat_truncated (stat_truncated),
    .stat_frames    (stat_frames)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus knobs (percentages and frame length range)
  int p_valid, p_ready, p_enable, p_err, len_lo, len_hi;

  // Source-side state: current frame length, beat position, held beat
  int         cur_len [S];
  int         cur_pos [S];
  logic [7:0] bd [S];
  logic       bu [S];
  logic       sv [S];

  // Reference model state
  int owner, last_g, gidx, out_cnt, frames, n_trunc;
  bit drain, trunc_pend, rec_tid;
  int tid_q[$];

  task automatic new_beat(input int i);
    bd[i] = 8'($urandom);
    bu[i] = ($urandom_range(0, 99) < p_err);
  endtask

  task automatic new_frame(input int i);
    cur_len[i] = $urandom_range(len_lo, len_hi);
    cur_pos[i] = 0;
    new_beat(i);
  endtask

  task automatic sources_reset();
    for (int i = 0; i < S; i++) begin
      sv[i] = 1'b0;
      new_frame(i);
    end
  endtask

  task automatic model_reset();
    owner      = -1;
    last_g     = S - 1;
    gidx       = 0;
    out_cnt    = 0;
    frames     = 0;
    drain      = 1'b0;
    trunc_pend = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < S; i++) begin
      if (!sv[i]) sv[i] = ($urandom_range(0, 99) < p_valid);
      s_axis_tvalid[i]        = sv[i];
      s_axis_tdata[i*DW +: DW] = bd[i];
      s_axis_tlast[i]         = (cur_pos[i] == cur_len[i] - 1);
      s_axis_tuser[i*UW +: UW] = bu[i];
    end
    m_axis_tready = ($urandom_range(0, 99) < p_ready);
    enable        = ($urandom_range(0, 99) < p_enable);
  endtask

  // Compare this cycle's outputs with the model, then advance the model to
  // the state it must hold after the coming clock edge.
  task automatic check_and_update();
    logic [S-1:0] exp_rdy;
    logic exp_mv, hs, cut, exp_last;
    int o;
    o = owner;
    exp_rdy = '0;
    if (o >= 0) exp_rdy[o] = drain ? 1'b1 : m_axis_tready;
    exp_mv = (o >= 0) && !drain && s_axis_tvalid[o];
    check_eq("s_tready", 32'(s_axis_tready), 32'(exp_rdy));
    check_eq("m_tvalid", 32'(m_axis_tvalid), 32'(exp_mv));
    check_eq("grant_valid", 32'(grant_valid), 32'(o >= 0));
    check_eq("grant_index", 32'(grant_index), gidx);
    check_eq("stat_trunc", 32'(stat_truncated), 32'(trunc_pend));
    check_eq("stat_frames", stat_frames, frames);
    trunc_pend = 1'b0;
    hs = exp_mv && m_axis_tready;
    if (hs) begin
      cut      = !s_axis_tlast[o] && (out_cnt == MAXL - 1);
      exp_last = s_axis_tlast[o] || cut;
      check_eq("m_tdata", 32'(m_axis_tdata), 32'(bd[o]));
      check_eq("m_tid", 32'(m_axis_tid), o);
      check_eq("m_tlast", 32'(m_axis_tlast), 32'(exp_last));
      check_eq("m_tuser", 32'(m_axis_tuser), 32'(bu[o] | cut));
      if (rec_tid && out_cnt == 0) tid_q.push_back(int'(m_axis_tid));
      out_cnt++;
      if (exp_last) begin
        frames++;
        $display("[TB] frame %0d src=%0d beats=%0d %s", frames, o, out_cnt,
                 cut ? "truncated" : "complete");
        if (cut) begin
          drain      = 1'b1;
          trunc_pend = 1'b1;
          n_trunc++;
        end else begin
          last_g  = o;
          owner   = -1;
          out_cnt = 0;
        end
      end
    end else if (o >= 0 && drain && s_axis_tvalid[o] && s_axis_tlast[o]) begin
      last_g  = o;
      owner   = -1;
      drain   = 1'b0;
      out_cnt = 0;
    end else if (o < 0 && enable && (|s_axis_tvalid)) begin
      for (int k = 1; k <= S; k++) begin
        if (owner < 0 && s_axis_tvalid[(last_g + k) % S]) owner = (last_g + k) % S;
      end
      gidx = owner;
    end
    for (int i = 0; i < S; i++) begin
      if (sv[i] && exp_rdy[i]) begin
        sv[i] = 1'b0;
        if (cur_pos[i] == cur_len[i] - 1) new_frame(i);
        else begin
          cur_pos[i]++;
          new_beat(i);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check_and_update();
  endtask

  task automatic set_knobs(input int pv, input int pr, input int pe, input int perr,
                           input int lo, input int hi);
    p_valid = pv; p_ready = pr; p_enable = pe; p_err = perr; len_lo = lo; len_hi = hi;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_s_tready"}, 32'(s_axis_tready), 32'd0);
    check_eq({pfx, "_m_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check_eq({pfx, "_m_tdata"}, 32'(m_axis_tdata), 32'd0);
    check_eq({pfx, "_m_tlast"}, 32'(m_axis_tlast), 32'd0);
    check_eq({pfx, "_m_tid"}, 32'(m_axis_tid), 32'd0);
    check_eq({pfx, "_grant_valid"}, 32'(grant_valid), 32'd0);
    check_eq({pfx, "_stat_frames"}, stat_frames, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_tid [5];
    int cyc;
    exp_tid = '{0, 1, 2, 3, 0};
    n_trunc = 0;
    rec_tid = 1'b0;

    // Reset with every source requesting: nothing may be granted or emitted.
    set_knobs(100, 100, 100, 0, 3, 3);
    sources_reset();
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      check_reset_outputs("rst");
      check_eq("rst_grant_index", 32'(grant_index), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check_and_update();

    // Round robin with all sources always requesting 3-beat frames.
    rec_tid = 1'b1;
    cyc = 0;
    while (frames < 5 && cyc < 200) begin
      step();
      cyc++;
    end
    rec_tid = 1'b0;
    check_eq("rr_done", frames, 5);
    for (int i = 0; i < 5; i++)
      check_eq($sformatf("rr_tid%0d", i), (i < tid_q.size()) ? tid_q[i] : 32'hFFFF, exp_tid[i]);
    step();
    check_eq("rr_stat_frames", stat_frames, 32'd5);

    // Random backpressure, lengths straddling the truncation limit.
    set_knobs(70, 60, 95, 10, 1, 12);
    repeat (1500) step();

    // Enable gating.
    set_knobs(80, 70, 40, 10, 1, 6);
    repeat (800) step();

    // Lengths concentrated around the limit: exact-limit and runaway frames.
    set_knobs(85, 80, 90, 5, 7, 11);
    repeat (800) step();
    check_eq("trunc_seen", 32'(n_trunc > 0), 32'd1);

    // Asynchronous reset in the middle of a frame.
    set_knobs(90, 80, 100, 0, 5, 10);
    cyc = 0;
    while (!(owner >= 0 && !drain && out_cnt > 0) && cyc < 100) begin
      step();
      cyc++;
    end
    check_eq("midrst_in_frame", 32'(owner >= 0), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    @(negedge clk);
    sources_reset();
    model_reset();
    rst_n = 1'b1;
    drive();
    #1;
    check_and_update();
    set_knobs(70, 70, 90, 10, 1, 12);
    repeat (500) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
